key_reader: RTL

KEY_READER -- requirements
Module: key_reader

---
 rtl/key_reader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/key_reader.sv
// Debounced key reader with sticky press events, W1C event register and irq.
// Define KEY_READER_RELEASE_EVT_EN to also latch release events in EVENT[15:8].
module key_reader #(
   parameter int NKEYS           = 4,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NKEYS-1:0] keys_in,
   input  logic [63:0]      daddr,
   input  logic             rw,
   input  logic [1:0]       word,
   input  logic [63:0]      wdata,
   output logic [63:0]      rdata,
   output logic             irq
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [63:0] A_STATE = 64'h1028;
   localparam logic [63:0] A_EVENT = 64'h1030;

   typedef enum logic {ST_STABLE, ST_COUNTING} state_t;

   logic [NKEYS-1:0] r_sync1;
   logic [NKEYS-1:0] r_sync2;
   logic [NKEYS-1:0] r_stable;
   state_t           r_state [NKEYS];
   logic [CW-1:0]    r_cnt   [NKEYS];
   logic [NKEYS-1:0] r_press;

   logic [NKEYS-1:0] w_done;
   logic [NKEYS-1:0] w_rise;
   logic [NKEYS-1:0] w_fall;
   logic             w_wr_evt;
   logic [NKEYS-1:0] w_clr_press;
   logic [NKEYS-1:0] w_clr_rel;
   logic [7:0]       w_press8;
   logic [7:0]       w_rel8;
   logic             w_unused;

   // A key completes when its count is exhausted and sync2 still disagrees.
   always_comb begin
      w_done = '0;
      for (int k = 0; k < NKEYS; k++) begin
         w_done[k] = (r_state[k] == ST_COUNTING) &&
                     (r_sync2[k] != r_stable[k]) &&
                     (r_cnt[k] == LAST);
      end
   end

   assign w_rise = w_done & r_sync2;
   assign w_fall = w_done & ~r_sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_stable <= '0;
         for (int k = 0; k < NKEYS; k++) begin
            r_state[k] <= ST_STABLE;
            r_cnt[k]   <= '0;
         end
      end else begin
         r_sync1 <= keys_in;
         r_sync2 <= r_sync1;
         for (int k = 0; k < NKEYS; k++) begin
            unique case (r_state[k])
               ST_STABLE: begin
                  if (r_sync2[k] != r_stable[k]) begin
                     r_state[k] <= ST_COUNTING;
                     r_cnt[k]   <= CW'(1);
                  end
               end
               ST_COUNTING: begin
                  if (r_sync2[k] == r_stable[k]) begin
                     r_state[k] <= ST_STABLE;
                     r_cnt[k]   <= '0;
                  end else if (w_done[k]) begin
                     r_stable[k] <= r_sync2[k];
                     r_state[k]  <= ST_STABLE;
                     r_cnt[k]    <= '0;
                  end else begin
                     r_cnt[k] <= r_cnt[k] + CW'(1);
                  end
               end
            endcase
         end
      end
   end

   assign w_wr_evt    = rw && (daddr == A_EVENT);
   assign w_clr_press = w_wr_evt ? wdata[NKEYS-1:0] : '0;
   assign w_clr_rel   = w_wr_evt ? wdata[8 +: NKEYS] : '0;

   // Set beats clear so an edge coinciding with a W1C is never lost.
   always_ff @(posedge clk) begin
      if (rst) r_press <= '0;
      else     r_press <= (r_press & ~w_clr_press) | w_rise;
   end

   assign w_press8 = 8'(r_press);

`ifdef KEY_READER_RELEASE_EVT_EN
   logic [NKEYS-1:0] r_rel;

   always_ff @(posedge clk) begin
      if (rst) r_rel <= '0;
      else     r_rel <= (r_rel & ~w_clr_rel) | w_fall;
   end

   assign w_rel8 = 8'(r_rel);
`else
   assign w_rel8 = 8'h00;
`endif

   assign w_unused = ^{word, wdata, w_fall, w_clr_rel};

   always_comb begin
      rdata = '0;
      if (!rw) begin
         if (daddr == A_STATE)      rdata = 64'(r_stable);
         else if (daddr == A_EVENT) rdata = {48'b0, w_rel8, w_press8};
      end
   end

   assign irq = (|w_press8) | (|w_rel8);

endmodule
